// File: rtl/t01_input_pkg.sv
// Shared types and default timing for the push-button input conditioner.
// The per-channel FSM states, the 25 MHz default cycle counts and the
// repeat-acceleration group size live here.
package t01_input_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    DAS    = 2'd2,
    REPEAT = 2'd3
  } t01_in_state_t;

  localparam int DEF_N_CH             = 8;
  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_DEBOUNCE_CYCLES  = 250000;
  localparam int DEF_DAS_DELAY_CYCLES = 4000000;
  localparam int DEF_ARR_CYCLES       = 1250000;

  // Number of consecutive repeat actions before the repeat interval halves
  // (only used when T01_INPUT_REPEAT_ACCEL_EN is defined).
  localparam int ACCEL_GROUP = 8;

endpackage

// File: rtl/t01_input_conditioner_if.sv
// Button bus between the raw pins / game FSM and the input conditioner.
// master: the side driving buttons and consuming pulses; slave: the conditioner.
interface t01_input_conditioner_if #(
  parameter int N_CH = 8
);

  logic            en;
  logic [N_CH-1:0] pb_i;
  logic [N_CH-1:0] repeat_mask_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] action_o;

  modport master (
    output en, pb_i, repeat_mask_i,
    input  level_o, press_o, release_o, action_o
  );

  modport slave (
    input  en, pb_i, repeat_mask_i,
    output level_o, press_o, release_o, action_o
  );

endinterface

// File: rtl/t01_input_channel.sv
// One button channel: synchroniser, debouncer, press/release edge pulses and
// DAS/ARR auto-repeat FSM. With T01_INPUT_REPEAT_ACCEL_EN defined, the repeat
// interval halves after every ACCEL_GROUP repeats, flooring at ARR_CYCLES/4.
module t01_input_channel
  import t01_input_pkg::*;
#(
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int DAS_DELAY_CYCLES = DEF_DAS_DELAY_CYCLES,
  parameter int ARR_CYCLES       = DEF_ARR_CYCLES
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic pb,
  input  logic repeat_mask,
  output logic level,
  output logic press,
  output logic rls,
  output logic action
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMAX = (DAS_DELAY_CYCLES > ARR_CYCLES) ? DAS_DELAY_CYCLES : ARR_CYCLES;
  localparam int TM_W = $clog2(TMAX) + 1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [DB_W-1:0]        db_cnt_r;
  logic                   stable_r;
  logic                   differ_s, settle_s, rise_s, fall_s;

  t01_in_state_t          state_r, state_nxt;
  logic [TM_W-1:0]        timer_r, timer_nxt, reload_s;
  logic                   tc_s;
  logic                   press_r, press_nxt;
  logic                   rls_r, rls_nxt;
  logic                   action_r, action_nxt;

  // Metastability synchroniser: shift raw pin through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) sync_r <= '0;
    else       sync_r <= {sync_r[SYNC_STAGES-2:0], pb};
  end

  assign sync_s   = sync_r[SYNC_STAGES-1];
  assign differ_s = (sync_s != stable_r);
  assign settle_s = differ_s && (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1));
  assign rise_s   = settle_s && sync_s;
  assign fall_s   = settle_s && !sync_s;

  // Debounce: count consecutive cycles of disagreement, accept on terminal count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      db_cnt_r <= '0;
      stable_r <= 1'b0;
    end else if (!differ_s || settle_s) begin
      db_cnt_r <= '0;
      stable_r <= sync_s;
    end else begin
      db_cnt_r <= db_cnt_r + DB_W'(1);
      stable_r <= stable_r;
    end
  end

  assign tc_s = (timer_r == '0);

`ifdef T01_INPUT_REPEAT_ACCEL_EN
  localparam int ACW       = $clog2(ACCEL_GROUP);
  localparam int ARR_FLOOR = ((ARR_CYCLES >> 2) > 0) ? (ARR_CYCLES >> 2) : 1;

  logic [TM_W-1:0] arr_int_r, arr_half_s;
  logic [ACW-1:0]  accel_cnt_r;
  logic            accel_tick_s, accel_hit_s;

  assign accel_tick_s = en && !fall_s && repeat_mask && (state_r == REPEAT) && tc_s;
  assign accel_hit_s  = (accel_cnt_r == ACW'(ACCEL_GROUP - 1));
  assign arr_half_s   = ((arr_int_r >> 1) < TM_W'(ARR_FLOOR)) ? TM_W'(ARR_FLOOR) : (arr_int_r >> 1);
  assign reload_s     = (accel_tick_s && accel_hit_s) ? arr_half_s : arr_int_r;

  // Repeat acceleration: halve the interval after each group of repeat ticks.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      arr_int_r   <= TM_W'(ARR_CYCLES);
      accel_cnt_r <= '0;
    end else if (state_nxt != REPEAT) begin
      arr_int_r   <= TM_W'(ARR_CYCLES);
      accel_cnt_r <= '0;
    end else if (accel_tick_s) begin
      if (accel_hit_s) begin
        arr_int_r   <= arr_half_s;
        accel_cnt_r <= '0;
      end else begin
        arr_int_r   <= arr_int_r;
        accel_cnt_r <= accel_cnt_r + ACW'(1);
      end
    end else begin
      arr_int_r   <= arr_int_r;
      accel_cnt_r <= accel_cnt_r;
    end
  end
`else
  assign reload_s = TM_W'(ARR_CYCLES);
`endif

  // Next-state and next-pulse logic; a debounced fall outranks any timer tick.
  always_comb begin
    state_nxt  = state_r;
    timer_nxt  = timer_r;
    press_nxt  = 1'b0;
    rls_nxt    = 1'b0;
    action_nxt = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else if (fall_s) begin
      rls_nxt   = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            press_nxt  = 1'b1;
            action_nxt = 1'b1;
            if (repeat_mask) begin
              state_nxt = DAS;
              timer_nxt = TM_W'(DAS_DELAY_CYCLES - 1);
            end else begin
              state_nxt = HELD;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        HELD: begin
          state_nxt = HELD;
        end
        DAS, REPEAT: begin
          if (!repeat_mask) begin
            state_nxt = HELD;
          end else if (tc_s) begin
            action_nxt = 1'b1;
            state_nxt  = REPEAT;
            timer_nxt  = reload_s - TM_W'(1);
          end else begin
            timer_nxt = timer_r - TM_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // FSM state, repeat timer and registered output pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r  <= IDLE;
      timer_r  <= '0;
      press_r  <= 1'b0;
      rls_r    <= 1'b0;
      action_r <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      timer_r  <= timer_nxt;
      press_r  <= press_nxt;
      rls_r    <= rls_nxt;
      action_r <= action_nxt;
    end
  end

  assign level  = stable_r;
  assign press  = press_r;
  assign rls    = rls_r;
  assign action = action_r;

endmodule

// File: rtl/t01_input_conditioner.sv
// N-channel push-button front end: one t01_input_channel per button, outputs
// packed onto the button bus. Optional repeat acceleration is enabled by
// defining T01_INPUT_REPEAT_ACCEL_EN.
module t01_input_conditioner
  import t01_input_pkg::*;
#(
  parameter int N_CH             = DEF_N_CH,
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int DAS_DELAY_CYCLES = DEF_DAS_DELAY_CYCLES,
  parameter int ARR_CYCLES       = DEF_ARR_CYCLES
) (
  input logic                    clk,
  input logic                    nrst,
  t01_input_conditioner_if.slave bus
);

  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] press_s;
  logic [N_CH-1:0] rls_s;
  logic [N_CH-1:0] action_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    t01_input_channel #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .DAS_DELAY_CYCLES (DAS_DELAY_CYCLES),
      .ARR_CYCLES       (ARR_CYCLES)
    ) u_ch (
      .clk         (clk),
      .nrst        (nrst),
      .en          (bus.en),
      .pb          (bus.pb_i[g]),
      .repeat_mask (bus.repeat_mask_i[g]),
      .level       (level_s[g]),
      .press       (press_s[g]),
      .rls         (rls_s[g]),
      .action      (action_s[g])
    );
  end

  assign bus.level_o   = level_s;
  assign bus.press_o   = press_s;
  assign bus.release_o = rls_s;
  assign bus.action_o  = action_s;

endmodule

// File: tb/tb_t01_input_conditioner.sv
// Directed self-checking bench for t01_input_conditioner with small timing
// constants (SYNC=2, DEBOUNCE=4, DAS=10, ARR=3). Edge e means the rising
// edge at which pb_i set just before it is sampled; outputs are sampled 1
// time unit after each edge.
module tb_t01_input_conditioner;

  localparam int N = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  t01_input_conditioner_if #(.N_CH(N)) bus ();

  t01_input_conditioner #(
    .N_CH             (N),
    .SYNC_STAGES      (2),
    .DEBOUNCE_CYCLES  (4),
    .DAS_DELAY_CYCLES (10),
    .ARR_CYCLES       (3)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.en            = 1'b1;
    bus.pb_i          = 8'h00;
    bus.repeat_mask_i = 8'h00;
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    bus.en = 1'b1; bus.pb_i = 8'h00; bus.repeat_mask_i = 8'h00;
    nrst = 1'b0;
    #2;
    n_checks++; if (bus.level_o   !== 8'h00) $display("FAIL reset level got %h exp 00", bus.level_o);   else n_pass++;
    n_checks++; if (bus.press_o   !== 8'h00) $display("FAIL reset press got %h exp 00", bus.press_o);   else n_pass++;
    n_checks++; if (bus.release_o !== 8'h00) $display("FAIL reset release got %h exp 00", bus.release_o); else n_pass++;
    n_checks++; if (bus.action_o  !== 8'h00) $display("FAIL reset action got %h exp 00", bus.action_o);  else n_pass++;
  endtask

  // ch0 no repeat: press at 5, release input at 20 -> release_o at 25.
  task automatic test_single_press;
    logic [7:0] el, ep, er, ea;
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      bus.pb_i = (e < 20) ? 8'h01 : 8'h00;
      tick();
      el = (e >= 5 && e < 25) ? 8'h01 : 8'h00;
      ep = (e == 5) ? 8'h01 : 8'h00;
      ea = (e == 5) ? 8'h01 : 8'h00;
      er = (e == 25) ? 8'h01 : 8'h00;
      n_checks++; if (bus.level_o   !== el) $display("FAIL single level e=%0d got %h exp %h", e, bus.level_o, el);   else n_pass++;
      n_checks++; if (bus.press_o   !== ep) $display("FAIL single press e=%0d got %h exp %h", e, bus.press_o, ep);   else n_pass++;
      n_checks++; if (bus.release_o !== er) $display("FAIL single release e=%0d got %h exp %h", e, bus.release_o, er); else n_pass++;
      n_checks++; if (bus.action_o  !== ea) $display("FAIL single action e=%0d got %h exp %h", e, bus.action_o, ea);  else n_pass++;
    end
  endtask

  // ch1 3-cycle glitch: nothing may come out.
  task automatic test_glitch;
    do_reset();
    for (int e = 0; e <= 15; e++) begin
      bus.pb_i = (e < 3) ? 8'h02 : 8'h00;
      tick();
      n_checks++; if (bus.level_o  !== 8'h00) $display("FAIL glitch level e=%0d got %h exp 00", e, bus.level_o);  else n_pass++;
      n_checks++; if (bus.press_o  !== 8'h00) $display("FAIL glitch press e=%0d got %h exp 00", e, bus.press_o);  else n_pass++;
      n_checks++; if (bus.action_o !== 8'h00) $display("FAIL glitch action e=%0d got %h exp 00", e, bus.action_o); else n_pass++;
    end
  endtask

  // ch2 auto-repeat: actions 5,15,18,21,24,27; fall at 30 beats the tick.
  // Then a second press released during DAS gives no repeat.
  task automatic test_repeat;
    logic [7:0] el, ep, er, ea;
    do_reset();
    bus.repeat_mask_i = 8'h04;
    for (int e = 0; e <= 33; e++) begin
      bus.pb_i = (e < 25) ? 8'h04 : 8'h00;
      tick();
      el = (e >= 5 && e < 30) ? 8'h04 : 8'h00;
      ep = (e == 5) ? 8'h04 : 8'h00;
      ea = (e == 5 || (e >= 15 && e < 30 && (e - 15) % 3 == 0)) ? 8'h04 : 8'h00;
      er = (e == 30) ? 8'h04 : 8'h00;
      n_checks++; if (bus.level_o   !== el) $display("FAIL repeat level e=%0d got %h exp %h", e, bus.level_o, el);   else n_pass++;
      n_checks++; if (bus.press_o   !== ep) $display("FAIL repeat press e=%0d got %h exp %h", e, bus.press_o, ep);   else n_pass++;
      n_checks++; if (bus.release_o !== er) $display("FAIL repeat release e=%0d got %h exp %h", e, bus.release_o, er); else n_pass++;
      n_checks++; if (bus.action_o  !== ea) $display("FAIL repeat action e=%0d got %h exp %h", e, bus.action_o, ea);  else n_pass++;
    end
    do_reset();
    bus.repeat_mask_i = 8'h04;
    for (int e = 0; e <= 20; e++) begin
      bus.pb_i = (e < 7) ? 8'h04 : 8'h00;
      tick();
      ea = (e == 5) ? 8'h04 : 8'h00;
      er = (e == 12) ? 8'h04 : 8'h00;
      n_checks++; if (bus.release_o !== er) $display("FAIL das_rel release e=%0d got %h exp %h", e, bus.release_o, er); else n_pass++;
      n_checks++; if (bus.action_o  !== ea) $display("FAIL das_rel action e=%0d got %h exp %h", e, bus.action_o, ea);  else n_pass++;
    end
  endtask

  // All channels together; release lands on the DAS terminal-count edge 15.
  task automatic test_all_channels;
    logic [7:0] el, ep, er, ea;
    do_reset();
    bus.repeat_mask_i = 8'hFF;
    for (int e = 0; e <= 20; e++) begin
      bus.pb_i = (e < 10) ? 8'hFF : 8'h00;
      tick();
      el = (e >= 5 && e < 15) ? 8'hFF : 8'h00;
      ep = (e == 5) ? 8'hFF : 8'h00;
      ea = (e == 5) ? 8'hFF : 8'h00;
      er = (e == 15) ? 8'hFF : 8'h00;
      n_checks++; if (bus.level_o   !== el) $display("FAIL all level e=%0d got %h exp %h", e, bus.level_o, el);   else n_pass++;
      n_checks++; if (bus.press_o   !== ep) $display("FAIL all press e=%0d got %h exp %h", e, bus.press_o, ep);   else n_pass++;
      n_checks++; if (bus.release_o !== er) $display("FAIL all release e=%0d got %h exp %h", e, bus.release_o, er); else n_pass++;
      n_checks++; if (bus.action_o  !== ea) $display("FAIL all action e=%0d got %h exp %h", e, bus.action_o, ea);  else n_pass++;
    end
  endtask

  // ch3 held in REPEAT, nrst pulsed after edge 19, released after edge 20:
  // immediate clear, then a fresh press at edge 26.
  task automatic test_mid_reset;
    logic [7:0] el, ep, ea;
    do_reset();
    bus.repeat_mask_i = 8'h08;
    for (int e = 0; e <= 30; e++) begin
      bus.pb_i = 8'h08;
      tick();
      if (e == 20) nrst = 1'b1;
      el = ((e >= 5 && e <= 19) || e >= 26) ? 8'h08 : 8'h00;
      ep = (e == 5 || e == 26) ? 8'h08 : 8'h00;
      ea = (e == 5 || e == 15 || e == 18 || e == 26) ? 8'h08 : 8'h00;
      n_checks++; if (bus.level_o  !== el) $display("FAIL mrst level e=%0d got %h exp %h", e, bus.level_o, el);  else n_pass++;
      n_checks++; if (bus.press_o  !== ep) $display("FAIL mrst press e=%0d got %h exp %h", e, bus.press_o, ep);  else n_pass++;
      n_checks++; if (bus.action_o !== ea) $display("FAIL mrst action e=%0d got %h exp %h", e, bus.action_o, ea); else n_pass++;
      if (e == 19) begin
        nrst = 1'b0;
        #1;
        n_checks++; if (bus.level_o  !== 8'h00) $display("FAIL mrst clr_level got %h exp 00", bus.level_o);  else n_pass++;
        n_checks++; if (bus.action_o !== 8'h00) $display("FAIL mrst clr_action got %h exp 00", bus.action_o); else n_pass++;
      end
    end
  endtask

  // ch4 pressed with en=0, en rises mid-hold (no press), release with en=1.
  task automatic test_enable;
    logic [7:0] el, er;
    do_reset();
    for (int e = 0; e <= 24; e++) begin
      bus.en   = (e >= 10) ? 1'b1 : 1'b0;
      bus.pb_i = (e < 15) ? 8'h10 : 8'h00;
      tick();
      el = (e >= 5 && e < 20) ? 8'h10 : 8'h00;
      er = (e == 20) ? 8'h10 : 8'h00;
      n_checks++; if (bus.level_o   !== el)    $display("FAIL en level e=%0d got %h exp %h", e, bus.level_o, el);      else n_pass++;
      n_checks++; if (bus.press_o   !== 8'h00) $display("FAIL en press e=%0d got %h exp 00", e, bus.press_o);          else n_pass++;
      n_checks++; if (bus.action_o  !== 8'h00) $display("FAIL en action e=%0d got %h exp 00", e, bus.action_o);        else n_pass++;
      n_checks++; if (bus.release_o !== er)    $display("FAIL en release e=%0d got %h exp %h", e, bus.release_o, er);  else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_repeat();
    test_all_channels();
    test_mid_reset();
    test_enable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/t01_input_conditioner.md
Name: t01_input_conditioner

Overview:
- N-channel push-button front end for the Tetris game.
- Generalises the per-button debounce instances into one parametrised block. Each channel gets a synchroniser, a debouncer, edge pulses, and Tetris-style auto-repeat: delayed auto shift (DAS) followed by a fixed auto-repeat rate (ARR).
- Sits between the raw pb[] pins and the game FSM. The FSM consumes action_o for left/right/rotate and level_o for soft-drop.

Parameters:
- N_CH, 8, number of button channels.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (>=2).
- DEBOUNCE_CYCLES, 250000, consecutive cycles a new synced level must hold before it is accepted (10 ms at 25 MHz).
- DAS_DELAY_CYCLES, 4000000, cycles from the press action to the first repeat action (160 ms).
- ARR_CYCLES, 1250000, cycles between subsequent repeat actions (50 ms).

Ports:
- clk, input, 1, system clock (25 MHz).
- nrst, input, 1, reset: asynchronous assert, active-low. Clears all state.
- en, input, 1, enables pulse outputs and the repeat machinery.
- pb_i, input, N_CH, raw active-high buttons; asynchronous to clk.
- repeat_mask_i, input, N_CH, 1 = channel auto-repeats while held.
- level_o, output, N_CH, debounced level.
- press_o, output, N_CH, 1-cycle pulse on debounced 0->1.
- release_o, output, N_CH, 1-cycle pulse on debounced 1->0.
- action_o, output, N_CH, 1-cycle pulse on press and on every repeat tick.

Behaviour:
- Reset: all outputs 0; sync chains, stable levels and counters 0; all FSMs in IDLE.
- Synchroniser: SYNC_STAGES flops per channel; sync = last stage.
- Debounce:
  - Counter clears whenever sync == stable.
  - Counter increments while sync != stable.
  - When the count reaches DEBOUNCE_CYCLES-1 and sync still differs, stable <= sync on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Latency: a clean level change sampled at edge k updates level_o, and fires press_o/release_o, at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. All outputs are registered.
- level_o is always stable, regardless of en.
- Per-channel FSM states:
  - IDLE: on a debounced rise with en=1, pulse press_o and action_o. Go to DAS if the mask bit is set, else HELD.
  - HELD: on a debounced fall, go to IDLE.
  - DAS: timer counts DAS_DELAY_CYCLES. At terminal count, pulse action_o, reload the timer with ARR_CYCLES, go to REPEAT.
  - REPEAT: pulse action_o every ARR_CYCLES.
- Edge and mask priorities:
  - A debounced fall in any state pulses release_o (if en=1) and goes to IDLE the same edge. A fall beats a simultaneous timer terminal count: no action_o.
  - A mask bit cleared while in DAS/REPEAT moves the channel to HELD next edge, with no further actions.
  - A mask bit set while in HELD has no effect until the next press.
- en=0:
  - press_o, release_o and action_o forced 0.
  - All FSMs forced to IDLE; debounce keeps running.
  - If en rises while a button is held, no press fires; the channel needs a fresh debounced rise.
- Channels are fully independent; simultaneous presses on all channels each produce their own pulses in the same cycle.
- Timer widths: $clog2 of the largest cycle constant (+1); no wrap is reachable.
- nrst asserted mid-operation: immediate clear. A button held through reset release yields a press after SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles, since stable restarts at 0.

Optional Feature:
- Macro: T01_INPUT_REPEAT_ACCEL_EN.
- Defined:
  - After each 8 consecutive repeat actions within one hold, the repeat interval halves.
  - The interval floors at ARR_CYCLES>>2.
  - The interval resets to ARR_CYCLES on release or on leaving REPEAT.
- Undefined: the interval is constant at ARR_CYCLES, and no acceleration counter is synthesised.

Decomposition:
- Package t01_input_pkg:
  - enum t01_in_state_t {IDLE, HELD, DAS, REPEAT};
  - default timing constants;
  - the ACCEL_GROUP=8 constant.
- Sub-module t01_input_channel: one channel's sync, debounce, FSM and timer. The top is a generate loop over N_CH plus output packing.

Test Plan (DEBOUNCE_CYCLES=4, DAS_DELAY_CYCLES=10, ARR_CYCLES=3, SYNC_STAGES=2, en=1):
- pb_i[0] rises at edge 0 and held, mask=0 -> level_o[0]=1, press_o[0] and action_o[0] pulse at edge 5; no further action_o; release at edge 20 -> release_o[0] at edge 25.
- 3-cycle pulse on pb_i[1] -> level_o, press_o and action_o stay 0 throughout.
- pb_i[2] held with mask[2]=1:
  - press/action at edge 5;
  - repeat actions at edges 15, 18, 21, ...;
  - release during DAS gives no repeat, only release_o.
- All 8 channels rise together -> press_o=8'hFF for exactly one cycle. Release on the DAS terminal-count edge -> release_o only, no action_o.
- Hold pb_i[3], pulse nrst low for 1 cycle mid-REPEAT -> outputs 0 immediately; a new press 5 cycles after release of reset. en=0 during a press -> no pulses, level_o still 1.
- With T01_INPUT_REPEAT_ACCEL_EN, held with mask=1, ARR_CYCLES=8 -> repeats at intervals 8 (x8), then 4 (x8), then 2 thereafter.
